// File: rtl/tl_d_arb_pkg.sv
// Shared TileLink D-channel definitions for the response arbiter: opcodes,
// arbiter state encoding and the beats-per-message helper.
package tl_d_arb_pkg;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] GRANT           = 3'd4;
  localparam logic [2:0] GRANT_DATA      = 3'd5;
  localparam logic [2:0] RELEASE_ACK     = 3'd6;

  localparam int DATA_BYTES = 8;
  localparam int DATA_SHIFT = $clog2(DATA_BYTES);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  // Oversized requests are clamped to max_size before the beat count is derived.
  function automatic logic [15:0] d_beats(input logic [2:0] opcode,
                                          input logic [3:0] size,
                                          input logic [3:0] max_size);
    logic [3:0] sz;
    sz = (size > max_size) ? max_size : size;
    if ((opcode == ACCESS_ACK_DATA || opcode == GRANT_DATA) && sz > 4'(DATA_SHIFT))
      d_beats = 16'd1 << (sz - 4'(DATA_SHIFT));
    else
      d_beats = 16'd1;
  endfunction

endpackage

// File: rtl/tl_d_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping past N-1 back to 0.
module tl_d_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          any
);

  assign any = |req;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    sel = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) sel = IW'(j);
    end
  end

endmodule

// File: rtl/tl_d_resp_arbiter.sv
// Merges N_IN TileLink D response streams onto one D port, round-robin at message
// boundaries with multi-beat locking. Optional stall counter: TL_D_RESP_ARB_STALL_CNT_EN.
module tl_d_resp_arbiter
  import tl_d_arb_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int MAX_SIZE    = 6,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic [3*N_IN-1:0]      in_opcode,
  input  logic [2*N_IN-1:0]      in_param,
  input  logic [4*N_IN-1:0]      in_size,
  input  logic [3*N_IN-1:0]      in_source,
  input  logic [N_IN-1:0]        in_sink,
  input  logic [N_IN-1:0]        in_denied,
  input  logic [N_IN-1:0]        in_corrupt,
  input  logic [64*N_IN-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_opcode,
  output logic [1:0]             out_param,
  output logic [3:0]             out_size,
  output logic [2:0]             out_source,
  output logic                   out_sink,
  output logic                   out_denied,
  output logic                   out_corrupt,
  output logic [63:0]            out_data
`ifdef TL_D_RESP_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int IW     = $clog2(N_IN);
  localparam int BEAT_W = (MAX_SIZE > DATA_SHIFT) ? MAX_SIZE - DATA_SHIFT + 1 : 1;

  if (N_IN < 2 || N_IN > 8 || MAX_SIZE > 15 || STALL_CNT_W < 1) begin : g_bad_param
    $error("tl_d_resp_arbiter: unsupported parameter combination");
  end

  logic [2:0]  op_a   [N_IN];
  logic [1:0]  par_a  [N_IN];
  logic [3:0]  size_a [N_IN];
  logic [2:0]  src_a  [N_IN];
  logic [63:0] data_a [N_IN];

  for (genvar i = 0; i < N_IN; i++) begin : g_unpack
    assign op_a[i]   = in_opcode[3*i +: 3];
    assign par_a[i]  = in_param[2*i +: 2];
    assign size_a[i] = in_size[4*i +: 4];
    assign src_a[i]  = in_source[3*i +: 3];
    assign data_a[i] = in_data[64*i +: 64];
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     lock_idx_q, lock_idx_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]     sel, cur_idx;
  logic              any_valid, fire;
  logic [15:0]       beats;

  tl_d_rr_picker #(.N(N_IN), .IW(IW)) u_picker (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .sel (sel),
    .any (any_valid)
  );

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N_IN - 1)) ? '0 : i + IW'(1);
  endfunction

  assign beats = d_beats(op_a[sel], size_a[sel], 4'(MAX_SIZE));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    beat_cnt_d = beat_cnt_q;
    cur_idx    = (state_q == BURST) ? lock_idx_q : sel;
    out_valid  = (state_q == BURST) ? in_valid[lock_idx_q] : any_valid;
    fire       = out_valid & out_ready;
    in_ready   = '0;
    if (out_valid) in_ready[cur_idx] = out_ready;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (beats == 16'd1) begin
            rr_ptr_d = next_idx(sel);
          end else begin
            lock_idx_d = sel;
            beat_cnt_d = BEAT_W'(beats - 16'd1);
            state_d    = BURST;
          end
        end
      end
      BURST: begin
        if (fire) begin
          beat_cnt_d = beat_cnt_q - BEAT_W'(1);
          if (beat_cnt_q == BEAT_W'(1)) begin
            rr_ptr_d = next_idx(lock_idx_q);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fields are forced to zero whenever nothing is being presented.
  always_comb begin
    out_opcode  = '0;
    out_param   = '0;
    out_size    = '0;
    out_source  = '0;
    out_sink    = 1'b0;
    out_denied  = 1'b0;
    out_corrupt = 1'b0;
    out_data    = '0;
    if (out_valid) begin
      out_opcode  = op_a[cur_idx];
      out_param   = par_a[cur_idx];
      out_size    = size_a[cur_idx];
      out_source  = src_a[cur_idx];
      out_sink    = in_sink[cur_idx];
      out_denied  = in_denied[cur_idx];
      out_corrupt = in_corrupt[cur_idx];
      out_data    = data_a[cur_idx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef TL_D_RESP_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tl_d_resp_arbiter.sv
// Self-checking bench for tl_d_resp_arbiter: per-input source queues drive the DUT,
// an expected-beat queue is popped and compared on every observed fire.
module tb_tl_d_resp_arbiter;
  import tl_d_arb_pkg::*;

  localparam int N    = 2;
  localparam int MAXS = 6;
  localparam int SW   = 4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [2:0]  source;
    logic        sink;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } beat_t;

  logic            clock, reset_n;
  logic [N-1:0]    in_valid, in_ready, in_sink, in_denied, in_corrupt;
  logic [3*N-1:0]  in_opcode, in_source;
  logic [2*N-1:0]  in_param;
  logic [4*N-1:0]  in_size;
  logic [64*N-1:0] in_data;
  logic            out_valid, out_ready;
  logic [2:0]      out_opcode, out_source;
  logic [1:0]      out_param;
  logic [3:0]      out_size;
  logic            out_sink, out_denied, out_corrupt;
  logic [63:0]     out_data;
  logic [SW-1:0]   stall_cnt;
  beat_t           out_b;

  tl_d_resp_arbiter #(.N_IN(N), .MAX_SIZE(MAXS), .STALL_CNT_W(SW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_param    (in_param),
    .in_size     (in_size),
    .in_source   (in_source),
    .in_sink     (in_sink),
    .in_denied   (in_denied),
    .in_corrupt  (in_corrupt),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_param   (out_param),
    .out_size    (out_size),
    .out_source  (out_source),
    .out_sink    (out_sink),
    .out_denied  (out_denied),
    .out_corrupt (out_corrupt),
    .out_data    (out_data)
`ifdef TL_D_RESP_ARB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

`ifndef TL_D_RESP_ARB_STALL_CNT_EN
  assign stall_cnt = '0;
`endif

  assign out_b = {out_opcode, out_param, out_size, out_source,
                  out_sink, out_denied, out_corrupt, out_data};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  beat_t src0_q[$];
  beat_t src1_q[$];
  beat_t exp_q[$];
  int    stall_at  = -1;
  int    stall_len = 0;
  int    stalled   = 0;
  int    fires     = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [2:0] op, input logic [3:0] sz, input int src, input int d);
    beat_t b;
    b.opcode  = op;
    b.param   = 2'(d);
    b.size    = sz;
    b.source  = 3'(src);
    b.sink    = d[0];
    b.denied  = d[1];
    b.corrupt = d[2];
    b.data    = (64'(src + 1) << 48) | 64'(32'hA000 + d);
    return b;
  endfunction

  task automatic add_src(input int idx, input beat_t b);
    if (idx == 0) src0_q.push_back(b);
    else          src1_q.push_back(b);
  endtask

  task automatic expect_beat(input beat_t b);
    exp_q.push_back(b);
  endtask

  task automatic drive();
    beat_t b0, b1;
    b0 = (src0_q.size() != 0) ? src0_q[0] : '0;
    b1 = (src1_q.size() != 0) ? src1_q[0] : '0;
    in_valid   = {src1_q.size() != 0, src0_q.size() != 0};
    in_opcode  = {b1.opcode, b0.opcode};
    in_param   = {b1.param, b0.param};
    in_size    = {b1.size, b0.size};
    in_source  = {b1.source, b0.source};
    in_sink    = {b1.sink, b0.sink};
    in_denied  = {b1.denied, b0.denied};
    in_corrupt = {b1.corrupt, b0.corrupt};
    in_data    = {b1.data, b0.data};
  endtask

  // One clock: drive after the edge, observe on the falling edge.
  task automatic cycle();
    beat_t e;
    if (fires == stall_at && stalled < stall_len) begin
      out_ready = 1'b0;
      stalled++;
    end else begin
      out_ready = 1'b1;
    end
    drive();
    @(negedge clock);
    check("out_valid", 96'(out_valid), 96'(exp_q.size() != 0));
    if (out_valid && out_ready) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 96'(out_b), 96'(e));
        check("in_ready", 96'(in_ready), 96'(N'(1) << e.source));
        if (in_ready[0])      void'(src0_q.pop_front());
        else if (in_ready[1]) void'(src1_q.pop_front());
        fires++;
      end
    end else if (out_valid) begin
      if (exp_q.size() != 0) check("hold_beat", 96'(out_b), 96'(exp_q[0]));
      check("stall_in_ready", 96'(in_ready), 96'(0));
    end else begin
      check("idle_fields", 96'(out_b), 96'(0));
      check("idle_in_ready", 96'(in_ready), 96'(0));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input string tag, input int exp_cyc);
    int cyc;
    cyc     = 0;
    fires   = 0;
    stalled = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      cycle();
      cyc++;
    end
    check({tag, "_cycles"}, 96'(cyc), 96'(exp_cyc));
    exp_q.delete();
    src0_q.delete();
    src1_q.delete();
    stall_at  = -1;
    stall_len = 0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    drive();
    #1;
    check("rst_out_valid", 96'(out_valid), 96'(0));
    check("rst_in_ready", 96'(in_ready), 96'(0));
    check("rst_fields", 96'(out_b), 96'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    beat_t a, b, c, d;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    drive();
    @(posedge clock);
    #1;
    pulse_reset();

    // Two single-beat acks at once: in0 then in1, then again from rr_ptr=0.
    a = mk(ACCESS_ACK, 4'd0, 0, 1); b = mk(ACCESS_ACK, 4'd0, 0, 2);
    c = mk(ACCESS_ACK, 4'd0, 1, 3); d = mk(ACCESS_ACK, 4'd0, 1, 4);
    add_src(0, a); add_src(0, b); add_src(1, c); add_src(1, d);
    expect_beat(a); expect_beat(c); expect_beat(b); expect_beat(d);
    run("rr_pair", 4);

    // Idle cycles must not move rr_ptr: in0 alone -> ptr=1, idle, then pair grants in1 first.
    a = mk(RELEASE_ACK, 4'd0, 0, 5);
    add_src(0, a); expect_beat(a);
    run("single0", 1);
    repeat (3) cycle();
    a = mk(ACCESS_ACK, 4'd0, 0, 6); c = mk(ACCESS_ACK, 4'd0, 1, 7);
    add_src(0, a); add_src(1, c);
    expect_beat(c); expect_beat(a);
    run("idle_keeps_ptr", 2);
    c = mk(ACCESS_ACK, 4'd0, 1, 8);
    add_src(1, c); expect_beat(c);
    run("single1", 1);

    // 8-beat burst locks out in1.
    for (int k = 0; k < 8; k++) begin
      a = mk(ACCESS_ACK_DATA, 4'd6, 0, k);
      add_src(0, a); expect_beat(a);
    end
    c = mk(ACCESS_ACK, 4'd0, 1, 9);
    add_src(1, c); expect_beat(c);
    run("burst8", 9);

    // Same burst with out_ready low for three cycles after beat 2.
    for (int k = 0; k < 8; k++) begin
      a = mk(ACCESS_ACK_DATA, 4'd6, 0, 16 + k);
      add_src(0, a); expect_beat(a);
    end
    c = mk(ACCESS_ACK, 4'd0, 1, 10);
    add_src(1, c); expect_beat(c);
    stall_at = 3; stall_len = 3;
    run("burst_stall", 12);

    // size=2 data ack is a single beat; ptr returns to 0.
    c = mk(ACCESS_ACK_DATA, 4'd2, 1, 11);
    add_src(1, c); expect_beat(c);
    run("small_data", 1);
    a = mk(ACCESS_ACK, 4'd0, 0, 12); c = mk(ACCESS_ACK, 4'd0, 1, 13);
    add_src(0, a); add_src(1, c);
    expect_beat(a); expect_beat(c);
    run("after_small", 2);

    // size above MAX_SIZE clamps to 8 beats.
    for (int k = 0; k < 8; k++) begin
      a = mk(ACCESS_ACK_DATA, 4'd9, 0, 32 + k);
      add_src(0, a); expect_beat(a);
    end
    c = mk(ACCESS_ACK, 4'd0, 1, 14);
    add_src(1, c); expect_beat(c);
    run("clamp", 9);

    // GrantData size 4 is two beats; Grant size 6 is one beat.
    for (int k = 0; k < 2; k++) begin
      a = mk(GRANT_DATA, 4'd4, 0, 48 + k);
      add_src(0, a); expect_beat(a);
    end
    c = mk(ACCESS_ACK, 4'd0, 1, 15);
    add_src(1, c); expect_beat(c);
    run("grant_data", 3);
    a = mk(GRANT, 4'd6, 0, 20); b = mk(GRANT, 4'd6, 0, 21); c = mk(ACCESS_ACK, 4'd0, 1, 22);
    add_src(0, a); add_src(0, b); add_src(1, c);
    expect_beat(a); expect_beat(c); expect_beat(b);
    run("grant_nodata", 3);

    // Reset mid-burst on in1; afterwards in0 must win from rr_ptr=0 in IDLE.
    for (int k = 0; k < 8; k++) begin
      c = mk(ACCESS_ACK_DATA, 4'd6, 1, 64 + k);
      add_src(1, c); expect_beat(c);
    end
    fires = 0;
    for (int k = 0; k < 20 && fires < 4; k++) cycle();
    check("pre_reset_fires", 96'(fires), 96'(4));
    pulse_reset();
    cycle();
    a = mk(ACCESS_ACK, 4'd0, 0, 23); c = mk(ACCESS_ACK, 4'd0, 1, 24);
    add_src(0, a); add_src(1, c);
    expect_beat(a); expect_beat(c);
    run("after_reset", 2);

`ifdef TL_D_RESP_ARB_STALL_CNT_EN
    pulse_reset();
    check("stall_cnt_rst", 96'(stall_cnt), 96'(0));
    a = mk(ACCESS_ACK, 4'd0, 0, 25);
    add_src(0, a); expect_beat(a);
    stall_at = 0; stall_len = 10;
    run("stall10", 11);
    check("stall_cnt10", 96'(stall_cnt), 96'(10));
    a = mk(ACCESS_ACK, 4'd0, 0, 26);
    add_src(0, a); expect_beat(a);
    stall_at = 0; stall_len = 20;
    run("stall20", 21);
    check("stall_cnt_sat", 96'(stall_cnt), 96'(15));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_d_resp_arbiter.md
Name: tl_d_resp_arbiter

Overview:
- Merges N TileLink D-channel response streams (64-bit data beats) from independent slaves onto one D channel toward the hart.
- Round-robin at message boundaries; multi-beat data messages are locked and never interleaved.
- Sits between the slave-side response ports and the hart D port that the hart-0 Insight D monitor taps.

Parameters:
- N_IN, 2, number of input D channels (2..8).
- MAX_SIZE, 6, largest legal log2 message size in bytes (64 B = 8 beats).
- STALL_CNT_W, 32, stall counter width; used only with the optional feature.

Ports:
- clock  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  N_IN  per-input D valid.
- in_ready  out  N_IN  per-input D ready.
- in_opcode  in  3*N_IN  packed per-input opcode; input i at [3i+:3].
- in_param  in  2*N_IN  packed param.
- in_size  in  4*N_IN  packed log2 size.
- in_source  in  3*N_IN  packed source ID.
- in_sink  in  N_IN  sink.
- in_denied  in  N_IN  denied.
- in_corrupt  in  N_IN  corrupt.
- in_data  in  64*N_IN  packed data beats.
- out_valid  out  1  merged D valid.
- out_ready  in  1  merged D ready.
- out_opcode, out_param, out_size, out_source, out_sink, out_denied, out_corrupt, out_data  out  3/2/4/3/1/1/1/64  merged D fields.
- stall_cnt  out  STALL_CNT_W  present only with the optional feature.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, beat_cnt=0, lock_idx=0. Outputs combinational: out_valid=0, in_ready=0, all out fields 0 while no input is valid.
- Beats per message:
  - opcode AccessAckData(1) or GrantData(5): beats = (size<=3) ? 1 : 1<<(size-3).
  - All other opcodes: 1 beat.
  - size>MAX_SIZE is clamped to MAX_SIZE.
- IDLE:
  - sel = first i with in_valid[i]=1, searching from rr_ptr upward with wrap.
  - out_* = in_*[sel]; out_valid = |in_valid; in_ready[sel] = out_ready; other in_ready = 0.
  - fire = out_valid & out_ready.
  - On fire with beats=1: rr_ptr <= (sel+1) mod N_IN; stay IDLE.
  - On fire with beats>1: lock_idx <= sel; beat_cnt <= beats-1; go to BURST.
- BURST:
  - Only lock_idx is selected; out_valid = in_valid[lock_idx]; all other in_ready = 0.
  - Each fire: beat_cnt-1.
  - Fire with beat_cnt==1: rr_ptr <= (lock_idx+1) mod N_IN; go to IDLE.
- Zero-bubble: combinational pass-through, 0-cycle latency. Back-to-back messages are granted in consecutive cycles.
- out_ready=0 holds state, beat_cnt and selection. A valid input must hold its fields (TileLink rule); the block does not register them.
- Empty: no valid input leaves rr_ptr unchanged.
- Reset mid-burst: the burst is abandoned and the block returns to IDLE/rr_ptr=0. Upstream is reset in the same domain.
- A lock is never broken by another input's valid. A burst-source in_valid drop mid-burst just stalls.

Optional Feature:
- Macro TL_D_RESP_ARB_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Counter increments each cycle out_valid & !out_ready and saturates at all-ones.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package tl_d_arb_pkg:
  - opcode localparams (ACCESS_ACK=0, ACCESS_ACK_DATA=1, GRANT=4, GRANT_DATA=5, RELEASE_ACK=6).
  - DATA_BYTES=8.
  - state enum {IDLE, BURST}.
  - function d_beats(opcode, size, max_size).
- One sub-module, tl_d_rr_picker: combinational round-robin first-one search from rr_ptr, outputs sel and any.

Test Plan:
1. in0 and in1 both present AccessAck (1 beat), out_ready=1 -> grants in0 at cycle 0, in1 at cycle 1; rr_ptr 0→1→0.
2. in0 AccessAckData size=6 with data 0..7; in1 valid throughout -> 8 consecutive in0 beats, in_ready[1]=0 for 8 cycles, then in1 granted at cycle 8.
3. Same burst with out_ready=0 on beats 3–5 -> beat_cnt holds at 5; data order preserved; 8 fires total; no in1 grant inside the burst.
4. in1 AccessAckData size=2 -> treated as 1 beat, state stays IDLE, rr_ptr → 0.
5. reset_n pulsed low mid-burst after beat 4 -> immediately IDLE, rr_ptr=0, out_valid follows inputs after release.
6. With TL_D_RESP_ARB_STALL_CNT_EN: out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10. With STALL_CNT_W=4 and 20 stall cycles -> stall_cnt saturates at 15.
